tilt_encoder: RTL and testbench

//  Producer side of the ball-movement tilt interface. Accepts signed X/Y accelerometer samples over a valid/ready handshake.

---
 rtl/tilt_encoder_if.sv | 24 ++
 rtl/tilt_encoder.sv | 213 +++++++++++++++++++++
 tb/tb_tilt_encoder.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tilt_encoder_if.sv
// Sample handshake bus between the accelerometer front end and tilt_encoder.
// Carries one signed X/Y pair per accepted valid/ready transfer.
interface tilt_encoder_if #(
    parameter int SW = 12
) ();
    logic                 sample_valid;
    logic                 sample_ready;
    logic signed [SW-1:0] x_sample;
    logic signed [SW-1:0] y_sample;

    modport master (
        output sample_valid,
        output x_sample,
        output y_sample,
        input  sample_ready
    );

    modport slave (
        input  sample_valid,
        input  x_sample,
        input  y_sample,
        output sample_ready
    );
endinterface

// File: rtl/tilt_encoder.sv
// Tilt encoder: block-averages X/Y samples, scales, clamps and drives
// the ball mover's direction flags and offset-binary tilt magnitudes.
module tilt_encoder #(
    parameter int SAMPLE_WIDTH       = 12,
    parameter int AVG_LOG2           = 2,
    parameter int SCALE_SHIFT        = 3,
    parameter int DEADZONE           = 8,
    parameter int STALE_CYCLES       = 10000000,
    parameter bit SIMULATE           = 1'b0,
    parameter int SIMULATE_STALE_CNT = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    tilt_encoder_if.slave        bus,
    output logic                 x_increment,
    output logic                 x_decrement,
    output logic                 y_increment,
    output logic                 y_decrement,
    output logic [7:0]           x_threshold,
    output logic [7:0]           y_threshold,
    output logic                 update_strobe,
    output logic                 stale
);

    localparam int AW = SAMPLE_WIDTH + AVG_LOG2;
    localparam int TIMEOUT = SIMULATE ? SIMULATE_STALE_CNT
                                      : STALE_CYCLES;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [AVG_LOG2-1:0] CNT_LAST = '1;
    localparam logic signed [AW-1:0] C_MAX = AW'(127);
    localparam logic signed [AW-1:0] C_MIN = AW'(-128);
    localparam logic signed [7:0] DZ_POS = 8'(DEADZONE);
    localparam logic signed [7:0] DZ_NEG = 8'(-DEADZONE);
    localparam logic [7:0] LEVEL = 8'd128;

    typedef enum logic [1:0] {
        ACCUM   = 2'd0,
        COMPUTE = 2'd1,
        UPDATE  = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic signed [AW-1:0] x_acc_q, x_acc_d;
    logic signed [AW-1:0] y_acc_q, y_acc_d;
    logic [AVG_LOG2-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic signed [7:0]    x_clamp_q, x_clamp_d;
    logic signed [7:0]    y_clamp_q, y_clamp_d;
    logic [7:0]           x_thr_q, x_thr_d;
    logic [7:0]           y_thr_q, y_thr_d;
    logic                 x_inc_q, x_inc_d;
    logic                 x_dec_q, x_dec_d;
    logic                 y_inc_q, y_inc_d;
    logic                 y_dec_q, y_dec_d;
    logic                 strobe_q, strobe_d;
    logic                 stale_q, stale_d;

    logic                 ready;
    logic                 accept;
    logic signed [AW-1:0] x_ext, y_ext;
    logic signed [AW-1:0] x_avg, y_avg;
    logic signed [AW-1:0] x_scaled, y_scaled;

    // Saturate a scaled average into the signed 8-bit tilt range.
    function automatic logic signed [7:0] clamp8(
        input logic signed [AW-1:0] v
    );
        logic signed [7:0] r;
        if (v > C_MAX) begin
            r = 8'sd127;
        end else if (v < C_MIN) begin
            r = -8'sd128;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    assign ready  = (state_q == ACCUM);
    assign accept = bus.sample_valid && ready;
    assign bus.sample_ready = ready;

    assign x_ext = AW'(bus.x_sample);
    assign y_ext = AW'(bus.y_sample);

    assign x_avg    = x_acc_q >>> AVG_LOG2;
    assign y_avg    = y_acc_q >>> AVG_LOG2;
    assign x_scaled = x_avg >>> SCALE_SHIFT;
    assign y_scaled = y_avg >>> SCALE_SHIFT;

    // Next-state logic: FSM sequencing, accumulation and stale override.
    always_comb begin
        state_d   = state_q;
        x_acc_d   = x_acc_q;
        y_acc_d   = y_acc_q;
        cnt_d     = cnt_q;
        timer_d   = timer_q + 1'b1;
        x_clamp_d = x_clamp_q;
        y_clamp_d = y_clamp_q;
        x_thr_d   = x_thr_q;
        y_thr_d   = y_thr_q;
        x_inc_d   = x_inc_q;
        x_dec_d   = x_dec_q;
        y_inc_d   = y_inc_q;
        y_dec_d   = y_dec_q;
        strobe_d  = 1'b0;
        stale_d   = stale_q;

        unique case (state_q)
            ACCUM: begin
                if (accept) begin
                    x_acc_d = x_acc_q + x_ext;
                    y_acc_d = y_acc_q + y_ext;
                    cnt_d   = cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = COMPUTE;
                    end
                end
            end
            COMPUTE: begin
                x_clamp_d = clamp8(x_scaled);
                y_clamp_d = clamp8(y_scaled);
                x_acc_d   = '0;
                y_acc_d   = '0;
                cnt_d     = '0;
                state_d   = UPDATE;
            end
            UPDATE: begin
                x_thr_d  = {~x_clamp_q[7], x_clamp_q[6:0]};
                y_thr_d  = {~y_clamp_q[7], y_clamp_q[6:0]};
                x_inc_d  = (x_clamp_q > DZ_POS);
                x_dec_d  = (x_clamp_q < DZ_NEG);
                y_inc_d  = (y_clamp_q > DZ_POS);
                y_dec_d  = (y_clamp_q < DZ_NEG);
                strobe_d = 1'b1;
                stale_d  = 1'b0;
                state_d  = ACCUM;
            end
            default: begin
                state_d = ACCUM;
            end
        endcase

        // An accepted sample always beats a simultaneous timeout.
        if (accept) begin
            timer_d = '0;
        end else if (timer_q == T_LAST) begin
            timer_d  = '0;
            x_acc_d  = '0;
            y_acc_d  = '0;
            cnt_d    = '0;
            x_thr_d  = LEVEL;
            y_thr_d  = LEVEL;
            x_inc_d  = 1'b0;
            x_dec_d  = 1'b0;
            y_inc_d  = 1'b0;
            y_dec_d  = 1'b0;
            strobe_d = 1'b0;
            stale_d  = 1'b1;
            state_d  = ACCUM;
        end
    end

    // State and output registers; reset restores neutral, stale outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ACCUM;
            x_acc_q   <= '0;
            y_acc_q   <= '0;
            cnt_q     <= '0;
            timer_q   <= '0;
            x_clamp_q <= '0;
            y_clamp_q <= '0;
            x_thr_q   <= LEVEL;
            y_thr_q   <= LEVEL;
            x_inc_q   <= 1'b0;
            x_dec_q   <= 1'b0;
            y_inc_q   <= 1'b0;
            y_dec_q   <= 1'b0;
            strobe_q  <= 1'b0;
            stale_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            x_acc_q   <= x_acc_d;
            y_acc_q   <= y_acc_d;
            cnt_q     <= cnt_d;
            timer_q   <= timer_d;
            x_clamp_q <= x_clamp_d;
            y_clamp_q <= y_clamp_d;
            x_thr_q   <= x_thr_d;
            y_thr_q   <= y_thr_d;
            x_inc_q   <= x_inc_d;
            x_dec_q   <= x_dec_d;
            y_inc_q   <= y_inc_d;
            y_dec_q   <= y_dec_d;
            strobe_q  <= strobe_d;
            stale_q   <= stale_d;
        end
    end

    assign x_increment   = x_inc_q;
    assign x_decrement   = x_dec_q;
    assign y_increment   = y_inc_q;
    assign y_decrement   = y_dec_q;
    assign x_threshold   = x_thr_q;
    assign y_threshold   = y_thr_q;
    assign update_strobe = strobe_q;
    assign stale         = stale_q;

endmodule

// File: tb/tb_tilt_encoder.sv
// Directed bench for tilt_encoder: averaging, clamp, deadzone,
// back-pressure, stale timeout and mid-block reset.
module tb_tilt_encoder;

    logic       clk;
    logic       rst_n;
    logic       x_inc, x_dec, y_inc, y_dec;
    logic [7:0] x_thr, y_thr;
    logic       strobe, stale;

    int total = 0;
    int bad   = 0;

    tilt_encoder_if #(.SW(12)) bus ();

    tilt_encoder #(
        .SIMULATE(1'b1),
        .SIMULATE_STALE_CNT(20)
    ) dut (
        .clk          (clk),
        .reset        (rst_n),
        .bus          (bus),
        .x_increment  (x_inc),
        .x_decrement  (x_dec),
        .y_increment  (y_inc),
        .y_decrement  (y_dec),
        .x_threshold  (x_thr),
        .y_threshold  (y_thr),
        .update_strobe(strobe),
        .stale        (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One transfer: wait (bounded) for ready, then present data for an edge.
    task automatic send(input int x, input int y);
        int k;
        @(negedge clk);
        k = 0;
        while (!bus.sample_ready && k < 8) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", {31'd0, bus.sample_ready}, 1);
        bus.sample_valid = 1'b1;
        bus.x_sample     = x[11:0];
        bus.y_sample     = y[11:0];
        @(posedge clk);
    endtask

    task automatic idle();
        @(negedge clk);
        bus.sample_valid = 1'b0;
    endtask

    task automatic send_block(input int xs[4], input int ys[4]);
        for (int i = 0; i < 4; i++) send(xs[i], ys[i]);
        idle();
    endtask

    task automatic send_const(input int x, input int y);
        int xs[4];
        int ys[4];
        for (int i = 0; i < 4; i++) begin
            xs[i] = x;
            ys[i] = y;
        end
        send_block(xs, ys);
    endtask

    // Called at the negedge after the accepting edge; ends after edge +2.
    task automatic expect_update(input string tag);
        @(negedge clk);
        chk({tag, "_strobe_e1"}, {31'd0, strobe}, 0);
        @(negedge clk);
        chk({tag, "_strobe_e2"}, {31'd0, strobe}, 1);
        chk({tag, "_stale"}, {31'd0, stale}, 0);
    endtask

    task automatic expect_x(input string tag, input int thr,
                            input bit inc, input bit dec);
        chk({tag, "_x_thr"}, {24'd0, x_thr}, thr);
        chk({tag, "_x_inc"}, {31'd0, x_inc}, {31'd0, inc});
        chk({tag, "_x_dec"}, {31'd0, x_dec}, {31'd0, dec});
    endtask

    task automatic expect_y(input string tag, input int thr,
                            input bit inc, input bit dec);
        chk({tag, "_y_thr"}, {24'd0, y_thr}, thr);
        chk({tag, "_y_inc"}, {31'd0, y_inc}, {31'd0, inc});
        chk({tag, "_y_dec"}, {31'd0, y_dec}, {31'd0, dec});
    endtask

    task automatic expect_neutral(input string tag);
        expect_x(tag, 128, 1'b0, 1'b0);
        expect_y(tag, 128, 1'b0, 1'b0);
        chk({tag, "_stale"}, {31'd0, stale}, 1);
        chk({tag, "_strobe"}, {31'd0, strobe}, 0);
    endtask

    initial begin
        int xs[4];
        int ys[4];
        int acc_n;
        int strobe_n;

        rst_n            = 1'b0;
        bus.sample_valid = 1'b0;
        bus.x_sample     = '0;
        bus.y_sample     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: reset state
        expect_neutral("s1");
        chk("s1_ready", {31'd0, bus.sample_ready}, 1);

        // 2: +400 on X, strobe exactly one cycle
        send_const(400, 0);
        expect_update("s2");
        expect_x("s2", 178, 1'b1, 1'b0);
        expect_y("s2", 128, 1'b0, 1'b0);
        @(negedge clk);
        chk("s2_strobe_e3", {31'd0, strobe}, 0);
        chk("s2_x_hold", {24'd0, x_thr}, 178);

        // 3: negative clamp on Y
        send_const(0, -2048);
        expect_update("s3");
        expect_x("s3", 128, 1'b0, 1'b0);
        expect_y("s3", 0, 1'b0, 1'b1);

        // 4: deadzone boundary, both signs
        send_const(64, 0);
        expect_update("s4a");
        expect_x("s4a", 136, 1'b0, 1'b0);
        send_const(72, 0);
        expect_update("s4b");
        expect_x("s4b", 137, 1'b1, 1'b0);
        send_const(-72, -64);
        expect_update("s4c");
        expect_x("s4c", 119, 1'b0, 1'b1);
        expect_y("s4c", 120, 1'b0, 1'b0);

        // positive clamp
        send_const(2047, 2047);
        expect_update("s4d");
        expect_x("s4d", 255, 1'b1, 1'b0);
        expect_y("s4d", 255, 1'b1, 1'b0);

        // mixed block; Y sum -3 must floor to -1
        xs = '{100, 200, 300, 401};
        ys = '{-1, -1, -1, 0};
        send_block(xs, ys);
        expect_update("s4e");
        expect_x("s4e", 159, 1'b1, 1'b0);
        expect_y("s4e", 127, 1'b0, 1'b0);

        // 5: valid held high for 30 cycles
        @(negedge clk);
        acc_n    = 0;
        strobe_n = 0;
        bus.sample_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (i > 0) @(negedge clk);
            chk("s5_ready", {31'd0, bus.sample_ready},
                ((i % 6) < 4) ? 1 : 0);
            if (bus.sample_ready) acc_n++;
            if (strobe) strobe_n++;
            bus.x_sample = 12'(i * 8);
            bus.y_sample = 12'(-(i * 8));
            @(posedge clk);
        end
        idle();
        chk("s5_accepted", acc_n, 20);
        chk("s5_strobes", strobe_n, 4);
        chk("s5_last_strobe", {31'd0, strobe}, 1);
        expect_x("s5", 153, 1'b1, 1'b0);
        expect_y("s5", 102, 1'b0, 1'b1);

        // 6: stale boundary, 20 edges after the last accept
        repeat (17) @(negedge clk);
        chk("s6_stale_19", {31'd0, stale}, 0);
        chk("s6_x_hold_19", {24'd0, x_thr}, 153);
        @(negedge clk);
        expect_neutral("s6_to");

        // timeout discards a partial block
        send(2047, 2047);
        send(2047, 2047);
        idle();
        repeat (25) @(negedge clk);
        send_const(400, 0);
        expect_update("s6_part");
        expect_x("s6_part", 178, 1'b1, 1'b0);
        expect_y("s6_part", 128, 1'b0, 1'b0);

        // reset mid-block, then a clean block
        send(-2048, -2048);
        send(-2048, -2048);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        expect_neutral("s6_rst");
        chk("s6_rst_ready", {31'd0, bus.sample_ready}, 1);
        bus.sample_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_const(400, 0);
        expect_update("s6_post");
        expect_x("s6_post", 178, 1'b1, 1'b0);
        expect_y("s6_post", 128, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
